uart_rx_buffer: RTL

Serial receive front end for the 6809 UART path. It oversamples the FT2232 TX line in the 8 MHz domain, deframes 8N1 characters, and queues them in a show-ahead FIFO. `uart_interface` consumes this FIFO when the CPU reads the UART data register. The block also supplies receive status bits and the active-low receive interrupt request.

---
 rtl/uart_rx_buffer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 oversampling receiver feeding a show-ahead FIFO.
// Supplies receive status, sticky error flags and the active-low IRQ.
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 69,
    parameter int FIFO_DEPTH   = 16,
    parameter int PTR_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_UART_TX,
    input  logic             i_rd_strobe,
    input  logic             i_clear,
    input  logic             i_irq_en,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_avail,
    output logic             o_fifo_full,
    output logic [PTR_W:0]   o_count,
    output logic             o_overrun,
    output logic             o_framing_err,
    output logic             o_irq_n
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Line synchronizer and edge history
    logic sync1_q;
    logic rx_s_q;
    logic rx_prev_q;

    // Receiver state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             stop_bad;

    // FIFO state
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             irq_n_q;
    logic             full;
    logic             empty;
    logic             pop;
    logic             wr_en;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= i_UART_TX;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Receiver next state: mid-bit sampling, LSB first, push on good stop
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        push = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign pop   = i_rd_strobe && !empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign wr_en = push && (!full || pop);

    // FIFO storage; no reset needed, reads are gated by the count
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO bookkeeping and sticky flags; clear outranks push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        ferr_d   = ferr_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovr_d    = 1'b0;
            ferr_d   = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count_d = count_q + (PTR_W + 1)'(1);
            end else if (pop && !wr_en) begin
                count_d = count_q - (PTR_W + 1)'(1);
            end
            if (push && !wr_en) begin
                ovr_d = 1'b1;
            end
            if (stop_bad) begin
                ferr_d = 1'b1;
            end
        end
    end

    // FIFO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    // Interrupt request follows the visible status by one clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= !(i_irq_en && (o_rx_avail || ovr_q));
        end
    end

    assign o_rx_data     = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign o_rx_avail    = !empty;
    assign o_fifo_full   = full;
    assign o_count       = count_q;
    assign o_overrun     = ovr_q;
    assign o_framing_err = ferr_q;
    assign o_irq_n       = irq_n_q;

endmodule
